// File: rtl/calc_seq_ctrl_if.sv
// Key-side and datapath-control signal bundle for calc_seq_ctrl.
// master: the controller; slave: keypad/datapath side.
interface calc_seq_ctrl_if #(
  parameter int KEY_W = 4
);
  logic             trig;
  logic [KEY_W-1:0] value;
  logic             clr_entry;
  logic             shift_en;
  logic [KEY_W-1:0] digit;
  logic             clr_in;
  logic             load_a;
  logic             load_b;
  logic             load_r;
  logic             load_ou;
  logic             addsub;
  logic             iu_au;
  logic             busy;
  logic             ovf;
  logic [1:0]       state;

  modport master (
    input  trig, value, clr_entry,
    output shift_en, digit, clr_in,
    output load_a, load_b, load_r, load_ou,
    output addsub, iu_au, busy, ovf, state
  );

  modport slave (
    output trig, value, clr_entry,
    input  shift_en, digit, clr_in,
    input  load_a, load_b, load_r, load_ou,
    input  addsub, iu_au, busy, ovf, state
  );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Calculator key-sequencing controller: key sync/edge detect,
// digit entry, operator chaining and repeated equals.
module calc_seq_ctrl #(
  parameter int DIGITS = 2,
  parameter int KEY_W  = 4
) (
  input logic            clk,
  input logic            clr_all,
  calc_seq_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    ENTER_A, OP, ENTER_B, RESULT
  } state_t;

  typedef enum logic [3:0] {
    P_IDLE, P_EQ_R, P_EQ_OU,
    P_CH_R, P_CH_A, P_CH_CLR,
    P_RD_SH, P_RO_CLR,
    P_RE_R, P_RE_OU
  } phase_t;

  localparam logic [3:0] MAX = 4'(DIGITS);

  logic s1_q, s2_q, ed_q;
  logic key_ev, is_dig, is_op, is_eq;

  state_t           state_q, n_state;
  phase_t           phase_q, n_phase;
  logic [3:0]       cnt_q, n_cnt;
  logic [KEY_W-1:0] digit_q, n_digit;
  logic [KEY_W-1:0] key_q, n_key;
  logic ovf_q, n_ovf, addsub_q, n_addsub;
  logic iu_au_q, n_iu_au, busy_q, n_busy;
  logic pend_q, n_pend;
  logic sh_q, n_sh, clr_q, n_clr;
  logic la_q, n_la, lb_q, n_lb;
  logic lr_q, n_lr, lou_q, n_lou;

  // flops preset to 1 so a key held over reset release is not seen
  assign key_ev = s2_q & ~ed_q;
  assign is_dig = bus.value < KEY_W'(10);
  assign is_op  = (bus.value == KEY_W'(10)) ||
                  (bus.value == KEY_W'(11));
  assign is_eq  = bus.value == KEY_W'(15);

  always_comb begin
    n_state  = state_q;
    n_phase  = phase_q;
    n_cnt    = cnt_q;
    n_ovf    = ovf_q;
    n_addsub = addsub_q;
    n_iu_au  = iu_au_q;
    n_digit  = digit_q;
    n_key    = key_q;
    n_sh     = 1'b0;
    n_clr    = 1'b0;
    n_la     = 1'b0;
    n_lb     = 1'b0;
    n_lr     = 1'b0;
    n_lou    = pend_q;
    n_pend   = 1'b0;
    n_busy   = 1'b0;
    case (phase_q)
      P_IDLE: begin
        if (!busy_q && !bus.clr_entry) begin
          n_clr = 1'b1;
          n_cnt = '0;
          n_ovf = 1'b0;
          if (state_q == RESULT) begin
            n_state = ENTER_A;
            n_iu_au = 1'b0;
          end
        end else if (!busy_q && key_ev) begin
          case (state_q)
            ENTER_A, ENTER_B: begin
              unique case (1'b1)
                is_dig: begin
                  if (cnt_q < MAX) begin
                    n_sh    = 1'b1;
                    n_digit = bus.value;
                    n_cnt   = cnt_q + 4'd1;
                    n_pend  = 1'b1;
                  end else begin
                    n_ovf = 1'b1;
                  end
                end
                is_op: begin
                  if (state_q == ENTER_A) begin
                    n_la     = 1'b1;
                    n_clr    = 1'b1;
                    n_addsub = bus.value[0];
                    n_cnt    = '0;
                    n_state  = OP;
                  end else begin
                    n_lb    = 1'b1;
                    n_busy  = 1'b1;
                    n_key   = bus.value;
                    n_phase = P_CH_R;
                  end
                end
                is_eq: begin
                  if (state_q == ENTER_B) begin
                    n_lb    = 1'b1;
                    n_busy  = 1'b1;
                    n_phase = P_EQ_R;
                  end
                end
                default: ;
              endcase
            end
            OP: begin
              unique case (1'b1)
                is_dig: begin
                  n_sh    = 1'b1;
                  n_digit = bus.value;
                  n_cnt   = 4'd1;
                  n_state = ENTER_B;
                end
                is_op:   n_addsub = bus.value[0];
                default: ;
              endcase
            end
            RESULT: begin
              unique case (1'b1)
                is_dig: begin
                  n_iu_au = 1'b0;
                  n_clr   = 1'b1;
                  n_busy  = 1'b1;
                  n_key   = bus.value;
                  n_phase = P_RD_SH;
                end
                is_op: begin
                  n_la    = 1'b1;
                  n_iu_au = 1'b1;
                  n_busy  = 1'b1;
                  n_key   = bus.value;
                  n_phase = P_RO_CLR;
                end
                is_eq: begin
                  n_la    = 1'b1;
                  n_iu_au = 1'b1;
                  n_busy  = 1'b1;
                  n_phase = P_RE_R;
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
      P_EQ_R, P_CH_R, P_RE_R: begin
        n_lr    = 1'b1;
        n_busy  = 1'b1;
        n_phase = (phase_q == P_EQ_R) ? P_EQ_OU :
                  (phase_q == P_CH_R) ? P_CH_A : P_RE_OU;
      end
      P_EQ_OU: begin
        n_iu_au = 1'b1;
        n_lou   = 1'b1;
        n_busy  = 1'b1;
        n_state = RESULT;
        n_phase = P_IDLE;
      end
      P_CH_A: begin
        n_iu_au = 1'b1;
        n_la    = 1'b1;
        n_busy  = 1'b1;
        n_phase = P_CH_CLR;
      end
      P_CH_CLR, P_RO_CLR: begin
        n_iu_au  = 1'b0;
        n_clr    = 1'b1;
        n_addsub = key_q[0];
        n_cnt    = '0;
        n_busy   = 1'b1;
        n_state  = OP;
        n_phase  = P_IDLE;
      end
      P_RD_SH: begin
        n_sh    = 1'b1;
        n_digit = key_q;
        n_cnt   = 4'd1;
        n_busy  = 1'b1;
        n_state = ENTER_A;
        n_phase = P_IDLE;
      end
      P_RE_OU: begin
        n_lou   = 1'b1;
        n_busy  = 1'b1;
        n_phase = P_IDLE;
      end
      default: n_phase = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_all) begin
    if (!clr_all) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      ed_q     <= 1'b1;
      state_q  <= ENTER_A;
      phase_q  <= P_IDLE;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      addsub_q <= 1'b0;
      iu_au_q  <= 1'b0;
      digit_q  <= '0;
      key_q    <= '0;
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
      sh_q     <= 1'b0;
      clr_q    <= 1'b0;
      la_q     <= 1'b0;
      lb_q     <= 1'b0;
      lr_q     <= 1'b0;
      lou_q    <= 1'b0;
    end else begin
      s1_q     <= bus.trig;
      s2_q     <= s1_q;
      ed_q     <= s2_q;
      state_q  <= n_state;
      phase_q  <= n_phase;
      cnt_q    <= n_cnt;
      ovf_q    <= n_ovf;
      addsub_q <= n_addsub;
      iu_au_q  <= n_iu_au;
      digit_q  <= n_digit;
      key_q    <= n_key;
      busy_q   <= n_busy;
      pend_q   <= n_pend;
      sh_q     <= n_sh;
      clr_q    <= n_clr;
      la_q     <= n_la;
      lb_q     <= n_lb;
      lr_q     <= n_lr;
      lou_q    <= n_lou;
    end
  end

  assign bus.shift_en = sh_q;
  assign bus.digit    = digit_q;
  assign bus.clr_in   = clr_q;
  assign bus.load_a   = la_q;
  assign bus.load_b   = lb_q;
  assign bus.load_r   = lr_q;
  assign bus.load_ou  = lou_q;
  assign bus.addsub   = addsub_q;
  assign bus.iu_au    = iu_au_q;
  assign bus.busy     = busy_q;
  assign bus.ovf      = ovf_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed table, timing corner cases,
// and random keys against an arithmetic calculator model.
module tb_calc_seq_ctrl;
  localparam int DIGITS = 2;
  localparam int KEY_W  = 4;

  logic clk = 1'b0;
  logic clr_all = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  calc_seq_ctrl_if #(.KEY_W(KEY_W)) bus ();

  calc_seq_ctrl #(.DIGITS(DIGITS), .KEY_W(KEY_W)) dut (
    .clk(clk),
    .clr_all(clr_all),
    .bus(bus)
  );

  always #5 clk = ~clk;

  wire [4:0] pls = {bus.shift_en, bus.load_a, bus.load_b,
                    bus.load_r, bus.load_ou};

  // datapath driven by the controller's pulses
  int iu, a, b, r, ou;
  always @(posedge clk or negedge clr_all) begin
    if (!clr_all) begin
      iu <= 0; a <= 0; b <= 0; r <= 0; ou <= 0;
    end else begin
      if (bus.clr_in) iu <= 0;
      else if (bus.shift_en) iu <= iu * 10 + int'(bus.digit);
      if (bus.load_a) a <= bus.iu_au ? r : iu;
      if (bus.load_b) b <= iu;
      if (bus.load_r) r <= bus.addsub ? a - b : a + b;
      if (bus.load_ou) ou <= bus.iu_au ? r : iu;
    end
  end

  logic [4:0] prev_p = '0;
  always @(negedge clk) begin
    if (clr_all && |pls) begin
      n_chk++;
      if (|(pls & prev_p)) begin
        n_fail++;
        $display("FAIL pulse_width: got %b after %b", pls, prev_p);
      end
    end
    prev_p <= pls;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // calculator-level reference
  int m_st, m_entry, m_cnt, m_a, m_b, m_r, m_disp;
  int m_ovf, m_sub;

  task automatic model_reset();
    m_st = 0; m_entry = 0; m_cnt = 0; m_a = 0; m_b = 0;
    m_r = 0; m_disp = 0; m_ovf = 0; m_sub = 0;
  endtask

  function automatic int calc(input int x, input int y, input int s);
    return (s != 0) ? x - y : x + y;
  endfunction

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (m_st == 0 || m_st == 2) begin
        if (m_cnt < DIGITS) begin
          m_entry = m_entry * 10 + k;
          m_cnt++;
          m_disp = m_entry;
        end else m_ovf = 1;
      end else begin
        m_entry = k;
        m_cnt = 1;
        m_st = (m_st == 1) ? 2 : 0;
      end
    end else if (k == 10 || k == 11) begin
      if (m_st == 0) m_a = m_entry;
      if (m_st == 2) begin
        m_b = m_entry;
        m_r = calc(m_a, m_b, m_sub);
        m_a = m_r;
      end
      if (m_st == 3) m_a = m_r;
      if (m_st != 1) begin
        m_entry = 0;
        m_cnt = 0;
      end
      m_sub = k - 10;
      m_st = 1;
    end else if (k == 15) begin
      if (m_st == 2) begin
        m_b = m_entry;
        m_r = calc(m_a, m_b, m_sub);
        m_disp = m_r;
        m_st = 3;
      end else if (m_st == 3) begin
        m_a = m_r;
        m_r = calc(m_a, m_b, m_sub);
        m_disp = m_r;
      end
    end
  endtask

  task automatic model_clr();
    m_entry = 0; m_cnt = 0; m_ovf = 0;
    if (m_st == 3) m_st = 0;
  endtask

  task automatic press(input int k);
    bus.value = 4'(k);
    repeat (5) @(posedge clk);
    #1 bus.trig = 1'b1;
    repeat (8) @(posedge clk);
    #1 bus.trig = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_clr();
    @(negedge clk) bus.clr_entry = 1'b0;
    @(negedge clk);
    chk("clr_in", int'(bus.clr_in), 1);
    bus.clr_entry = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) clr_all = 1'b0;
    @(negedge clk) clr_all = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_state"}, int'(bus.state), m_st);
    chk({tag, "_ou"}, ou, m_disp);
    chk({tag, "_iu"}, iu, m_entry);
    chk({tag, "_a"}, a, m_a);
    chk({tag, "_ovf"}, int'(bus.ovf), m_ovf);
    chk({tag, "_addsub"}, int'(bus.addsub), m_sub);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  typedef struct {
    int clr; int key; int st; int disp; int ovf; int sub;
  } vec_t;
  vec_t vecs[24];

  initial begin
    vecs = '{
      '{0, 1, 0, 1, 0, 0},   '{0, 2, 0, 12, 0, 0},
      '{0, 3, 0, 12, 1, 0},  '{1, 0, 0, 12, 0, 0},
      '{0, 1, 0, 1, 0, 0},   '{0, 10, 1, 1, 0, 0},
      '{0, 2, 2, 1, 0, 0},   '{0, 15, 3, 3, 0, 0},
      '{0, 15, 3, 5, 0, 0},  '{0, 7, 0, 5, 0, 0},
      '{0, 5, 0, 75, 0, 0},  '{0, 11, 1, 75, 0, 1},
      '{0, 10, 1, 75, 0, 0}, '{0, 3, 2, 75, 0, 0},
      '{0, 10, 1, 75, 0, 0}, '{0, 4, 2, 75, 0, 0},
      '{0, 15, 3, 82, 0, 0}, '{0, 11, 1, 82, 0, 1},
      '{0, 2, 2, 82, 0, 1},  '{0, 15, 3, 80, 0, 1},
      '{0, 12, 3, 80, 0, 1}, '{1, 0, 0, 80, 0, 1},
      '{0, 14, 0, 80, 0, 1}, '{0, 15, 0, 80, 0, 1}
    };
    bus.trig = 1'b1;
    bus.value = 4'h5;
    bus.clr_entry = 1'b1;
    model_reset();

    // reset with the key held, then no events after release
    repeat (3) @(negedge clk);
    chk("rst_outs", int'({pls, bus.clr_in, bus.addsub, bus.iu_au,
        bus.busy, bus.ovf}), 0);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_digit", int'(bus.digit), 0);
    clr_all = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("held_quiet", int'({pls, bus.clr_in, bus.busy}), 0);
    end
    bus.trig = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].clr != 0) apply_clr();
      else press(vecs[i].key);
      chk($sformatf("v%0d_state", i), int'(bus.state), vecs[i].st);
      chk($sformatf("v%0d_ou", i), ou, vecs[i].disp);
      chk($sformatf("v%0d_ovf", i), int'(bus.ovf), vecs[i].ovf);
      chk($sformatf("v%0d_sub", i), int'(bus.addsub), vecs[i].sub);
    end

    // equals timing, plus a key arriving during busy
    do_reset();
    press(4); press(10); press(5);
    bus.value = 4'hF;
    repeat (5) @(posedge clk);
    #1 bus.trig = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.trig = 1'b0;
    @(negedge clk);
    chk("lat_e2", int'(pls), 0);
    @(posedge clk);
    #1 bus.trig = 1'b1;
    @(negedge clk);
    chk("eq_s1_lb", int'(bus.load_b), 1);
    chk("eq_s1_busy", int'(bus.busy), 1);
    chk("eq_s1_src", int'(bus.iu_au), 0);
    @(negedge clk);
    chk("eq_s2_lr", int'(bus.load_r), 1);
    @(negedge clk);
    chk("eq_s3_lou", int'(bus.load_ou), 1);
    chk("eq_s3_src", int'(bus.iu_au), 1);
    chk("eq_s3_state", int'(bus.state), 3);
    chk("eq_s3_busy", int'(bus.busy), 1);
    @(negedge clk);
    chk("eq_end_busy", int'(bus.busy), 0);
    chk("eq_end_pls", int'(pls), 0);
    repeat (4) @(posedge clk);
    #1 bus.trig = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_ou", ou, 9);
    chk("drop_a", a, 4);
    chk("drop_state", int'(bus.state), 3);

    // clear-all in the middle of an equals sequence
    do_reset();
    press(1); press(11); press(2);
    bus.value = 4'hF;
    repeat (5) @(posedge clk);
    #1 bus.trig = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_s2_lr", int'(bus.load_r), 1);
    chk("mid_s2_sub", int'(bus.addsub), 1);
    clr_all = 1'b0;
    #1;
    chk("mid_rst_outs", int'({pls, bus.clr_in, bus.addsub,
        bus.iu_au, bus.busy, bus.ovf}), 0);
    chk("mid_rst_state", int'(bus.state), 0);
    @(negedge clk) clr_all = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    chk("mid_after_pls", int'(pls), 0);
    bus.trig = 1'b0;
    repeat (3) @(negedge clk);

    // random keys against the calculator model
    do_reset();
    for (int i = 0; i < 160; i++) begin
      int sel;
      int k;
      sel = int'($urandom_range(0, 99));
      if (sel < 10) begin
        apply_clr();
        model_clr();
      end else begin
        if (sel < 55) k = int'($urandom_range(0, 9));
        else if (sel < 75) k = 10 + int'($urandom_range(0, 1));
        else if (sel < 92) k = 15;
        else k = 12 + int'($urandom_range(0, 2));
        press(k);
        model_key(k);
      end
      check_model($sformatf("r%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Parametrised key-sequencing controller for the calculator datapath. It sits between the keypad encoder and the input unit, operand registers A/B, the add/sub arithmetic unit, result register R and the output unit. Key strobes are synchronised and edge-detected, then decoded into one-cycle load/shift/clear pulses. It supports multi-digit entry, operator change, chained operations and repeated equals, with the AU result fed back as operand A.

## Interface
Parameters:
- DIGITS, 2: maximum digits per operand entry (1..15)
- KEY_W, 4: key-code width

Ports:
- clk  in  1  system clock, rising edge
- clr_all  in  1  asynchronous active-low reset (clear-all key)
- trig  in  1  key strobe, asynchronous to clk; `value` is stable ≥4 clk before and while high
- value  in  KEY_W  key code: 0–9 digit, 0xA add, 0xB sub, 0xF equals, 0xC–0xE ignored
- clr_entry  in  1  active-low level, sampled synchronously: clear current entry
- shift_en  out  1  pulse: shift `digit` into input unit
- digit  out  KEY_W  registered digit code, valid with shift_en
- clr_in  out  1  pulse: clear input-unit register
- load_a, load_b, load_r, load_ou  out  1 each  active-high one-cycle load pulses
- addsub  out  1  level: 0 add, 1 subtract
- iu_au  out  1  level: operand/display source, 0 input unit, 1 AU/result
- busy  out  1  high while a multi-cycle sequence runs
- ovf  out  1  sticky: digit rejected, entry full
- state  out  2  0 ENTER_A, 1 OP, 2 ENTER_B, 3 RESULT

## Operation
- Sync chain: trig passes through 2 flops, then an edge flop. Key event = sync & ~edge. All three flops reset to 1, so a key held through reset release does not fire.
- Digit in ENTER_A or ENTER_B:
  - If cnt < DIGITS: shift_en with digit, cnt++. Next cycle: load_ou with iu_au=0.
  - Otherwise: set ovf, no shift.
- ENTER_A:
  - Operator: load_a and clr_in in the same cycle (A captures the pre-clear value). addsub := value[0], cnt := 0, go to OP.
  - Equals: ignored.
- OP:
  - Digit: shift_en, cnt := 1, go to ENTER_B.
  - Operator: update addsub only.
  - Equals: ignored.
- ENTER_B:
  - Equals sequence:
    - S1: load_b.
    - S2: load_r.
    - S3: iu_au := 1, load_ou. Go to RESULT.
  - Operator (chain) sequence:
    - S1: load_b.
    - S2: load_r.
    - S3: iu_au := 1, load_a.
    - S4: iu_au := 0, clr_in, addsub := new op, cnt := 0. Go to OP.
- RESULT:
  - Digit sequence:
    - S1: iu_au := 0, clr_in.
    - S2: shift_en, cnt := 1. Go to ENTER_A.
  - Operator: load_a (iu_au=1), then iu_au := 0, clr_in, addsub := op. Go to OP.
  - Equals (repeat last op with same B):
    - S1: load_a (iu_au=1).
    - S2: load_r.
    - S3: load_ou. Stay in RESULT.
- clr_entry low while not busy:
  - clr_in is high every cycle; cnt := 0; ovf := 0.
  - RESULT → ENTER_A with iu_au := 0. Other states hold.
  - Key events are dropped while clr_entry is low.
- Key event while busy: dropped; no pulse, no state change. clr_entry is sampled only after busy falls.
- Reserved codes 0xC–0xE: no effect in any state.

## Timing
- Reset (clr_all low, asynchronous): all pulses 0, addsub 0, iu_au 0, ovf 0, busy 0, cnt 0, digit 0, state ENTER_A. Takes effect immediately, including mid-sequence.
- Key latency: the first response pulse is registered at the 3rd rising clk edge after trig rises.
- Every pulse is exactly 1 cycle wide. Sequence steps S1..Sn occupy consecutive cycles.
- busy is high from S1 through the last step and falls the cycle after it.
- addsub and iu_au change only on the edges listed above and are stable whenever a load pulse is high.
- At most one key event per trig rising edge; holding trig high never repeats.

## Test plan
- Reset with trig=1, then release and hold trig → all outputs 0, state=0, no pulses for 20 cycles.
- DIGITS=2, keys 1,2,3 → shift_en twice (digit 1 then 2), each followed by load_ou; third key sets ovf=1 with no shift_en; clr_entry low 1 cycle → clr_in, ovf=0.
- Keys 1,A,2,F → load_a + clr_in with addsub=0; shift_en digit 2; then load_b, load_r, load_ou on consecutive cycles with iu_au=1; state=3.
- Then F again → load_a (iu_au=1), load_r, load_ou; state stays 3. Then digit 7 → clr_in, then shift_en digit 7; iu_au=0; state=0.
- Keys 5,B,A,3,A → addsub 1 then 0 in OP with no pulses. Final A: load_b, load_r, load_a (iu_au=1), then clr_in with iu_au=0; state=1.
- Key event during busy → ignored. clr_all low during S2 of equals → all outputs reset in the same cycle, state=0.
